// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - coefficient-update sequencer for the FIR coefficient RAM
// Streams NUM_TAP coefficients into RAM addresses 0..NUM_TAP-1 under one update-flag window.
module fir_coeff_loader #(
  parameter int NUM_TAP = 33,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iLoadStart,
  input  logic              iAbort,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeff,
  output logic              oCoeffReady,
  output logic              oCoeffiUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic              oBusy,
  output logic              oDone,
  output logic              oAbortFlag
);

  typedef enum logic [2:0] {IDLE, ARM, WRITE, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAP - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                flag_q, flag_d;
  logic                csn_q, csn_d;
  logic                wrn_q, wrn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                abort_flag_q, abort_flag_d;
  logic                handshake;

  assign oCoeffReady = (state_q == WRITE);
  assign handshake   = iCoeffValid & oCoeffReady;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flag_d       = flag_q;
    csn_d        = 1'b1;
    wrn_d        = 1'b1;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    abort_flag_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (iLoadStart) begin
          state_d = ARM;
          cnt_d   = '0;
          flag_d  = 1'b1;
        end
      end
      ARM: begin
        if (iAbort) begin
          state_d      = IDLE;
          flag_d       = 1'b0;
          abort_flag_d = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Abort wins over a same-cycle handshake: the word is never written.
        if (iAbort) begin
          state_d      = IDLE;
          flag_d       = 1'b0;
          abort_flag_d = 1'b1;
        end else if (handshake) begin
          csn_d   = 1'b0;
          wrn_d   = 1'b0;
          addr_d  = cnt_q;
          wdata_d = iCoeff;
          if (cnt_q == LAST_ADDR) begin
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
        flag_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        flag_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flag_q       <= 1'b0;
      csn_q        <= 1'b1;
      wrn_q        <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      abort_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      csn_q        <= csn_d;
      wrn_q        <= wrn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      abort_flag_q <= abort_flag_d;
    end
  end

  assign oCoeffiUpdateFlag = flag_q;
  assign oCsnRam           = csn_q;
  assign oWrnRam           = wrn_q;
  assign oAddrRam          = addr_q;
  assign oWrDtRam          = wdata_q;
  assign oBusy             = (state_q != IDLE);
  assign oDone             = done_q;
  assign oAbortFlag        = abort_flag_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - directed self-checking bench for fir_coeff_loader
module tb_fir_coeff_loader;
  localparam int NUM_TAP = 33;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;

  logic              clk = 1'b0;
  logic              iRst, iLoadStart, iAbort, iCoeffValid;
  logic [DATA_W-1:0] iCoeff;
  logic              oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam;
  logic [ADDR_W-1:0] oAddrRam;
  logic [DATA_W-1:0] oWrDtRam;
  logic              oBusy, oDone, oAbortFlag;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int nflag_viol = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];

  always #5 clk = ~clk;

  fir_coeff_loader #(.NUM_TAP(NUM_TAP), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .iClk_12M(clk), .iRst(iRst), .iLoadStart(iLoadStart), .iAbort(iAbort),
    .iCoeffValid(iCoeffValid), .iCoeff(iCoeff), .oCoeffReady(oCoeffReady),
    .oCoeffiUpdateFlag(oCoeffiUpdateFlag), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam),
    .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam), .oBusy(oBusy), .oDone(oDone),
    .oAbortFlag(oAbortFlag)
  );

  // RAM-side monitor: logs every strobe and every completion pulse
  always @(negedge clk) begin
    cyc++;
    if (oCsnRam === 1'b0 && oWrnRam === 1'b0) begin
      wr_addr.push_back(oAddrRam);
      wr_data.push_back(oWrDtRam);
      if (oCoeffiUpdateFlag !== 1'b1) nflag_viol++;
    end
    if (oDone === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iLoadStart = 1'b0; iAbort = 1'b0; iCoeffValid = 1'b0; iCoeff = '0;
    step(); step();
    checks++; if (oCoeffReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", oCoeffReady); end
    checks++; if (oCoeffiUpdateFlag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", oCoeffiUpdateFlag); end
    checks++; if (oCsnRam !== 1'b1 || oWrnRam !== 1'b1) begin errors++; $display("FAIL reset_strobes got=%b%b exp=11", oCsnRam, oWrnRam); end
    checks++; if (oAddrRam !== '0 || oWrDtRam !== '0) begin errors++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", oAddrRam, oWrDtRam); end
    checks++; if (oBusy !== 1'b0 || oDone !== 1'b0 || oAbortFlag !== 1'b0) begin errors++; $display("FAIL reset_status got=%b%b%b exp=000", oBusy, oDone, oAbortFlag); end
    iRst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n, c0, flag_bad, data_bad;
    logic hs;
    clear_logs();
    n = 0; flag_bad = 0; data_bad = 0;
    iCoeffValid = 1'b1; iCoeff = DATA_W'(1); iLoadStart = 1'b1;
    c0 = cyc;
    step();
    iLoadStart = 1'b0;
    checks++; if (oCoeffiUpdateFlag !== 1'b1 || oCoeffReady !== 1'b0 || oBusy !== 1'b1) begin errors++; $display("FAIL b2b_arm got flag=%b rdy=%b busy=%b exp=1 0 1", oCoeffiUpdateFlag, oCoeffReady, oBusy); end
    for (int t = 1; t <= 37; t++) begin
      if (oCoeffiUpdateFlag !== ((t >= 1 && t <= 35) ? 1'b1 : 1'b0)) flag_bad++;
      hs = oCoeffReady & iCoeffValid;
      step();
      if (hs) begin n++; iCoeff = DATA_W'(n + 1); end
    end
    iCoeffValid = 1'b0;
    checks++; if (wr_addr.size() != NUM_TAP) begin errors++; $display("FAIL b2b_writes got=%0d exp=%0d", wr_addr.size(), NUM_TAP); end
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== DATA_W'(i + 1)) data_bad++;
    checks++; if (data_bad != 0) begin errors++; $display("FAIL b2b_addr_data got=%0d bad exp=0", data_bad); end
    checks++; if (flag_bad != 0) begin errors++; $display("FAIL b2b_flag_window got=%0d bad cycles exp=0", flag_bad); end
    checks++; if (done_cnt != 1 || done_cyc - c0 != 36) begin errors++; $display("FAIL b2b_done got=%0d pulses at cycle %0d exp=1 at 36", done_cnt, done_cyc - c0); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp=0", oBusy); end
  endtask

  task automatic test_stalled();
    int n, c0, last_hs, data_bad, strobe_bad;
    logic hs, prev_hs;
    clear_logs();
    n = 0; last_hs = 0; data_bad = 0; strobe_bad = 0; prev_hs = 1'b0;
    iCoeff = '0; iLoadStart = 1'b1; iCoeffValid = 1'b0;
    c0 = cyc;
    step();
    iLoadStart = 1'b0;
    for (int t = 1; t <= 100 && done_cnt == 0; t++) begin
      if ((oCsnRam === 1'b0) !== prev_hs) strobe_bad++;
      iCoeffValid = (t % 2 == 0);
      hs = oCoeffReady & iCoeffValid;
      if (hs) last_hs = t;
      step();
      prev_hs = hs;
      if (hs) begin n++; iCoeff = DATA_W'(-n); end
    end
    iCoeffValid = 1'b0;
    checks++; if (wr_addr.size() != NUM_TAP) begin errors++; $display("FAIL stall_writes got=%0d exp=%0d", wr_addr.size(), NUM_TAP); end
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== DATA_W'(-i)) data_bad++;
    checks++; if (data_bad != 0) begin errors++; $display("FAIL stall_addr_data got=%0d bad exp=0", data_bad); end
    checks++; if (wr_data.size() > 1 && wr_data[1] !== 16'hFFFF) begin errors++; $display("FAIL stall_addr1 got=%h exp=ffff", wr_data[1]); end
    checks++; if (strobe_bad != 0) begin errors++; $display("FAIL stall_strobe_follow got=%0d bad exp=0", strobe_bad); end
    checks++; if (done_cnt != 1 || done_cyc - c0 != last_hs + 2) begin errors++; $display("FAIL stall_done got=%0d at %0d exp=1 at %0d", done_cnt, done_cyc - c0, last_hs + 2); end
    checks++; if (nflag_viol != 0) begin errors++; $display("FAIL strobe_outside_flag got=%0d exp=0", nflag_viol); end
    step();
  endtask

  task automatic test_abort();
    int n, guard;
    logic hs;
    clear_logs();
    n = 0; guard = 0;
    iCoeffValid = 1'b1; iCoeff = DATA_W'(1); iLoadStart = 1'b1;
    step();
    iLoadStart = 1'b0;
    while (iAbort !== 1'b1 && guard < 60) begin
      if (oCoeffReady && n == 9) iAbort = 1'b1;
      hs = oCoeffReady & iCoeffValid & ~iAbort;
      step();
      if (hs) begin n++; iCoeff = DATA_W'(n + 1); end
      guard++;
    end
    iAbort = 1'b0; iCoeffValid = 1'b0;
    checks++; if (oAbortFlag !== 1'b1 || oCoeffiUpdateFlag !== 1'b0 || oBusy !== 1'b0 || oCsnRam !== 1'b1) begin errors++; $display("FAIL abort_next got abt=%b flag=%b busy=%b csn=%b exp=1 0 0 1", oAbortFlag, oCoeffiUpdateFlag, oBusy, oCsnRam); end
    step();
    checks++; if (oAbortFlag !== 1'b0) begin errors++; $display("FAIL abort_pulse_width got=%b exp=0", oAbortFlag); end
    checks++; if (wr_addr.size() != 9 || wr_addr[wr_addr.size()-1] !== ADDR_W'(8)) begin errors++; $display("FAIL abort_writes got=%0d exp=9 ending at 8", wr_addr.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    clear_logs();
    iCoeffValid = 1'b1; iCoeff = 16'h00AA; iLoadStart = 1'b1;
    step();
    iLoadStart = 1'b0;
    for (int t = 1; t <= 37; t++) step();
    iCoeffValid = 1'b0;
    checks++; if (wr_addr.size() != NUM_TAP || wr_addr[0] !== '0) begin errors++; $display("FAIL abort_restart got=%0d writes exp=%0d from addr 0", wr_addr.size(), NUM_TAP); end
  endtask

  task automatic test_start_busy();
    clear_logs();
    iCoeffValid = 1'b1; iCoeff = 16'h1234; iLoadStart = 1'b1;
    step();
    iLoadStart = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      iLoadStart = (t == 5);
      step();
    end
    iLoadStart = 1'b0; iCoeffValid = 1'b0;
    checks++; if (wr_addr.size() != NUM_TAP) begin errors++; $display("FAIL busy_start_writes got=%0d exp=%0d", wr_addr.size(), NUM_TAP); end
    checks++; if (done_cnt != 1 || oBusy !== 1'b0) begin errors++; $display("FAIL busy_start_done got=%0d busy=%b exp=1 0", done_cnt, oBusy); end
  endtask

  task automatic test_reset_midload();
    int n, guard;
    logic hs;
    clear_logs();
    n = 0; guard = 0;
    iCoeffValid = 1'b1; iCoeff = 16'h0100; iLoadStart = 1'b1;
    step();
    iLoadStart = 1'b0;
    while (n < 20 && guard < 60) begin
      hs = oCoeffReady & iCoeffValid;
      step();
      if (hs) begin n++; iCoeff = DATA_W'(16'h0100 + n); end
      guard++;
    end
    iRst = 1'b1;
    step();
    checks++; if (oCoeffReady !== 1'b0 || oCoeffiUpdateFlag !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL rst_mid_status got rdy=%b flag=%b busy=%b exp=000", oCoeffReady, oCoeffiUpdateFlag, oBusy); end
    checks++; if (oCsnRam !== 1'b1 || oWrnRam !== 1'b1 || oAddrRam !== '0 || oWrDtRam !== '0) begin errors++; $display("FAIL rst_mid_ram got=%b%b %h %h exp=11 0 0", oCsnRam, oWrnRam, oAddrRam, oWrDtRam); end
    iRst = 1'b0;
    for (int t = 0; t < 5; t++) step();
    iCoeffValid = 1'b0;
    checks++; if (wr_addr.size() != 20 || done_cnt != 0) begin errors++; $display("FAIL rst_mid_writes got=%0d done=%0d exp=20 0", wr_addr.size(), done_cnt); end
  endtask

  task automatic test_abort_flush();
    int n, guard;
    logic hs;
    clear_logs();
    n = 0; guard = 0;
    iCoeffValid = 1'b1; iCoeff = DATA_W'(1); iLoadStart = 1'b1;
    step();
    iLoadStart = 1'b0;
    while (n < NUM_TAP && guard < 60) begin
      hs = oCoeffReady & iCoeffValid;
      step();
      if (hs) begin n++; iCoeff = DATA_W'(n + 1); end
      guard++;
    end
    iAbort = 1'b1; iCoeffValid = 1'b0;
    step();
    iAbort = 1'b0;
    checks++; if (oDone !== 1'b1 || oAbortFlag !== 1'b0) begin errors++; $display("FAIL flush_abort got done=%b abt=%b exp=1 0", oDone, oAbortFlag); end
    checks++; if (wr_addr.size() != NUM_TAP || wr_addr[wr_addr.size()-1] !== ADDR_W'(32) || wr_data[wr_data.size()-1] !== DATA_W'(33)) begin errors++; $display("FAIL flush_last_write got=%0d writes exp=%0d ending 32/0021", wr_addr.size(), NUM_TAP); end
    step();
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b exp=0", oBusy); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stalled();
    test_abort();
    test_start_busy();
    test_reset_midload();
    test_abort_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
